draw_scheduler: RTL and testbench
=================================

# draw_scheduler

Frame-synchronous scheduler that shares the single VGA adapter write port between several sprite plotters (user, alien, bullet, ...). On each frame tick it latches which plotters need drawing, starts them one at a time in fixed order with an enable pulse, routes the active plotter's pixel stream to the VGA adapter, and waits for its done pulse before moving on. A watchdog aborts a plotter that never reports done.

## Interface

Parameters:
- N_REQ, 4, number of plotter requesters (2..8)
- TIMEOUT, 1023, max WAIT cycles per plotter before abort
- IW, $clog2(N_REQ), width of grant index

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse, start of a draw pass
- req  in  N_REQ  level; requester i wants drawing this pass, sampled only on accepted frame_tick
- start  out  N_REQ  one-hot, one-cycle enable pulse to the granted plotter
- done_in  in  N_REQ  done pulses from plotters
- plot_in  in  N_REQ  per-plotter plot strobe
- x_in  in  9*N_REQ  packed x, slice i = [9i+8:9i]
- y_in  in  8*N_REQ  packed y, slice i = [8i+7:8i]
- colour_in  in  3*N_REQ  packed colour, slice i = [3i+2:3i]
- x  out  9  to VGA adapter
- y  out  8  to VGA adapter
- colour  out  3  to VGA adapter
- plot  out  1  to VGA adapter writeEn
- grant_idx  out  IW  index of current/last granted plotter
- busy  out  1  high in any state except IDLE
- pass_done  out  1  one-cycle pulse, pass complete
- timeout_err  out  1  sticky, a plotter was aborted
- overrun  out  1  sticky, frame_tick arrived while busy

## Operation

- States: IDLE, SELECT, START, WAIT, FINISH.
- IDLE: on frame_tick, pending <= req, go SELECT. Otherwise stay.
- SELECT: if pending == 0, go FINISH. Else grant_idx <= lowest set index of pending, go START. Index 0 is drawn first, so higher indices overdraw lower ones.
- START: start[grant_idx] = 1 for this cycle only. Clear pending[grant_idx]. Clear watchdog to 0. Go WAIT.
- WAIT: increment watchdog each cycle.
  - done_in[grant_idx] = 1: go SELECT.
  - Else if watchdog == TIMEOUT: set timeout_err, go SELECT.
  - If done and timeout coincide, done wins and timeout_err is not set.
- FINISH: pass_done = 1, go IDLE.
- Ignored inputs:
  - done_in from non-granted plotters, always.
  - done_in[grant_idx] in START.
  - req outside an accepted frame_tick.
- frame_tick when not in IDLE: ignored (no re-latch, pass continues), sets overrun.
- Pixel mux, combinational from grant_idx:
  - In START or WAIT: x, y, colour = slices[grant_idx]; plot = plot_in[grant_idx].
  - In all other states: x = 0, y = 0, colour = 0, plot = 0.
- Sticky flags clear only on reset.
- Reset (any time, including mid-pass):
  - State IDLE, pending = 0, grant_idx = 0, watchdog = 0, flags = 0.
  - All outputs 0 on the following cycle.
  - A plotter already started is not notified.

## Timing

- frame_tick at cycle T: SELECT at T+1; first start pulse at T+2; WAIT from T+3.
- done_in[g] at cycle D (in WAIT): SELECT at D+1; next start pulse at D+2. Inter-plotter gap is 2 cycles.
- Last plotter done at D: SELECT at D+1, pass_done at D+2, IDLE at D+3.
- Empty req on frame_tick at T: pass_done at T+2, busy low at T+3.
- Abort: watchdog reaches TIMEOUT in the WAIT cycle TIMEOUT+1 after start. timeout_err is high the next cycle.
- Pixel outputs have zero added latency: combinational from plot_in/x_in/y_in/colour_in.
- A new frame_tick is accepted in the first IDLE cycle after pass_done.

## Test plan

- Reset mid-WAIT with grant_idx = 2 -> next cycle: busy = 0, start = 0, x/y/colour/plot = 0, grant_idx = 0; flags 0.
- req = 4'b1011, frame_tick at T, each plotter done 5 cycles after its start:
  - start pulses 0001, 0010, 1000 in that order, at T+2, T+9, T+16.
  - pass_done at T+23; plot/x/y track the granted plotter only during START/WAIT.
- req = 0, frame_tick -> pass_done exactly 2 cycles later; start never asserted; busy high for 2 cycles.
- TIMEOUT = 15, plotter 1 never asserts done:
  - abort after 16 WAIT cycles; timeout_err = 1.
  - next pending plotter started 2 cycles later; pass completes normally.
- Spurious done_in[3] while plotter 0 is granted, then done_in[0] together with the watchdog reaching TIMEOUT -> done_in[3] ignored; advance on done; timeout_err stays 0.
- frame_tick reasserted during WAIT with req changed -> overrun = 1; original pending set unchanged; no extra start pulses.

Source files
------------

// File: rtl/draw_scheduler_if.sv
// -----------------------------------------------------------------------------
// draw_scheduler_if
// Bundles every non-clock signal of the draw scheduler: the frame trigger and
// request vector, the per-plotter start/done handshake, the packed per-plotter
// pixel streams, the muxed pixel stream towards the VGA adapter, and status.
//
// Modports:
//   slave  - the scheduler itself (consumes frame_tick/req/done/pixels,
//            produces start, muxed pixel, grant and status)
//   master - the surrounding system (frame timer, plotters, VGA adapter)
// -----------------------------------------------------------------------------
interface draw_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
);
  logic                 frame_tick;
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     start;
  logic [N_REQ-1:0]     done_in;
  logic [N_REQ-1:0]     plot_in;
  logic [9*N_REQ-1:0]   x_in;
  logic [8*N_REQ-1:0]   y_in;
  logic [3*N_REQ-1:0]   colour_in;
  logic [8:0]           x;
  logic [7:0]           y;
  logic [2:0]           colour;
  logic                 plot;
  logic [IW-1:0]        grant_idx;
  logic                 busy;
  logic                 pass_done;
  logic                 timeout_err;
  logic                 overrun;

  modport slave (
    input  frame_tick, req, done_in, plot_in, x_in, y_in, colour_in,
    output start, x, y, colour, plot, grant_idx, busy, pass_done,
           timeout_err, overrun
  );

  modport master (
    output frame_tick, req, done_in, plot_in, x_in, y_in, colour_in,
    input  start, x, y, colour, plot, grant_idx, busy, pass_done,
           timeout_err, overrun
  );
endinterface

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Shares the single VGA adapter write port between N_REQ sprite plotters.
// A frame_tick in IDLE latches the request vector; plotters are then started
// one at a time, lowest index first (so higher indices overdraw lower ones),
// and the granted plotter's pixel stream is routed to the adapter until it
// pulses done. A watchdog aborts a plotter that stays silent for TIMEOUT
// cycles of WAIT.
//
// Ports:
//   clk     - system clock, rising edge
//   resetn  - synchronous active-low reset
//   bus     - draw_scheduler_if.slave: frame_tick, req, start, done_in,
//             per-plotter pixel inputs, muxed x/y/colour/plot, grant_idx,
//             busy, pass_done, sticky timeout_err / overrun
// -----------------------------------------------------------------------------
module draw_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023,
  parameter int IW      = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              resetn,
  draw_scheduler_if.slave   bus
);

  localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q;
  logic [IW-1:0]    grant_q;
  logic [WDW-1:0]   watchdog_q;
  logic             timeout_q;
  logic             overrun_q;

  logic [IW-1:0]    lowest;
  logic             done_hit;
  logic             wd_expired;

  // Lowest set bit of pending; scanning downwards lets the lowest index win.
  always_comb begin
    lowest = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest = IW'(i);
    end
  end

  // Only the granted plotter's done line is ever looked at.
  always_comb begin
    done_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IW'(i)) done_hit = bus.done_in[i];
    end
  end

  assign wd_expired = (watchdog_q == WD_LIMIT);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q  <= '0;
      grant_q    <= '0;
      watchdog_q <= '0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:   if (bus.frame_tick) pending_q <= bus.req;
        S_SELECT: if (pending_q != '0) grant_q <= lowest;
        S_START: begin
          pending_q[grant_q] <= 1'b0;
          watchdog_q         <= '0;
        end
        S_WAIT: begin
          watchdog_q <= watchdog_q + WDW'(1);
          // A done arriving on the expiry cycle still counts as a clean finish.
          if (!done_hit && wd_expired) timeout_q <= 1'b1;
        end
        default: ;
      endcase
      // A tick while a pass is in flight is dropped but remembered.
      if (bus.frame_tick && state_q != S_IDLE) overrun_q <= 1'b1;
    end
  end

  // Next-state logic and all combinational outputs.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    bus.start     = '0;
    bus.x         = '0;
    bus.y         = '0;
    bus.colour    = '0;
    bus.plot      = 1'b0;
    bus.busy      = (state_q != S_IDLE);
    bus.pass_done = 1'b0;

    unique case (state_q)
      S_IDLE:   if (bus.frame_tick) state_d = S_SELECT;
      S_SELECT: state_d = (pending_q == '0) ? S_FINISH : S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (done_hit || wd_expired) state_d = S_SELECT;
      S_FINISH: begin
        bus.pass_done = 1'b1;
        state_d       = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase

    if (state_q == S_START) bus.start[grant_q] = 1'b1;

    // Pixel path is purely combinational so plotters see no extra latency.
    if (state_q == S_START || state_q == S_WAIT) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_q == IW'(i)) begin
          bus.x      = bus.x_in[9*i +: 9];
          bus.y      = bus.y_in[8*i +: 8];
          bus.colour = bus.colour_in[3*i +: 3];
          bus.plot   = bus.plot_in[i];
        end
      end
    end
  end

  assign bus.grant_idx   = grant_q;
  assign bus.timeout_err = timeout_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_draw_scheduler
// Self-checking bench for draw_scheduler (N_REQ = 4, TIMEOUT = 15).
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge. Plotters are modelled reactively: each one answers its
// observed start pulse with a done pulse after a per-plotter delay.
// -----------------------------------------------------------------------------
module tb_draw_scheduler;
  localparam int N    = 4;
  localparam int TO   = 15;
  localparam int MAXR = 100;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  draw_scheduler_if #(.N_REQ(N)) bus ();

  draw_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.frame_tick = 1'b0;
    bus.req        = '0;
    bus.done_in    = '0;
    bus.plot_in    = '0;
    bus.x_in       = '0;
    bus.y_in       = '0;
    bus.colour_in  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    to_drive();
    resetn = 1'b1;
  endtask

  // One full pass with reactive plotters; delay of plotter i is dly[8i+:8]
  // cycles after its start pulse (values above TO+1 mean "never").
  task automatic run_pass(input logic [3:0] rq, input logic [31:0] dly,
                          output int pd, output int last_st,
                          output logic [3:0] st_or, output int nst);
    int act, cnt;
    logic [3:0] d;
    act = -1; cnt = 0; pd = -1; last_st = 0; st_or = '0; nst = 0;
    bus.frame_tick = 1'b1;
    bus.req        = rq;
    bus.done_in    = '0;
    to_sample();
    to_drive();
    bus.frame_tick = 1'b0;
    for (int r = 1; r < 300 && pd < 0; r++) begin
      bus.req = 4'($urandom);
      d = '0;
      if (act >= 0) begin
        cnt++;
        if (cnt == int'(dly[8*act +: 8])) begin
          d[act] = 1'b1;
          act    = -1;
        end
      end
      bus.done_in = d;
      to_sample();
      if (bus.start != '0) begin
        last_st = r;
        st_or   = st_or | bus.start;
        nst++;
        for (int i = 0; i < N; i++) if (bus.start[i]) act = i;
        cnt = 0;
      end
      if (bus.pass_done) pd = r;
      to_drive();
    end
    bus.done_in = '0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] dly;
    int          exp_pd;
    int          exp_last;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  // Random-phase state (used by the main initial block only).
  logic [3:0] rq;
  int         dly_r [N];
  logic [3:0] exp_start [MAXR];
  int         exp_g     [MAXR];
  int         t, e, err_at, pd, act, cnt, g;
  logic       exp_err, exp_ovr, tick_now;
  logic [3:0] dn;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int pd_o, last_o, nst_o;
    logic [3:0] stor_o;
    logic [35:0] xs;

    vecs[0] = '{4'b0000, 32'h05050505, 2,  0,  1'b0};
    vecs[1] = '{4'b1011, 32'h05050505, 23, 16, 1'b0};
    vecs[2] = '{4'b0001, 32'h01010101, 5,  2,  1'b0};
    vecs[3] = '{4'b1111, 32'h05050505, 30, 23, 1'b0};
    vecs[4] = '{4'b1000, 32'h10101010, 20, 2,  1'b0};
    vecs[5] = '{4'b0100, 32'h63636363, 20, 2,  1'b1};
    vecs[6] = '{4'b0110, 32'h00056300, 27, 20, 1'b1};
    vecs[7] = '{4'b1001, 32'h10000003, 25, 7,  1'b0};

    // ---------------- reset state ----------------
    idle_inputs();
    resetn = 1'b0;
    to_drive();
    to_drive();
    to_sample();
    check("rst_busy",      bus.busy,        0);
    check("rst_start",     bus.start,       0);
    check("rst_pass_done", bus.pass_done,   0);
    check("rst_grant",     bus.grant_idx,   0);
    check("rst_plot",      bus.plot,        0);
    check("rst_tmo",       bus.timeout_err, 0);
    check("rst_ovr",       bus.overrun,     0);
    to_drive();
    resetn = 1'b1;

    // ---------------- table-driven passes ----------------
    foreach (vecs[v]) begin
      do_reset();
      run_pass(vecs[v].req, vecs[v].dly, pd_o, last_o, stor_o, nst_o);
      check($sformatf("vec%0d_pass_done_cycle", v), pd_o, vecs[v].exp_pd);
      check($sformatf("vec%0d_last_start", v), last_o, vecs[v].exp_last);
      check($sformatf("vec%0d_started_set", v), stor_o, vecs[v].req);
      check($sformatf("vec%0d_start_count", v), nst_o, $countones(vecs[v].req));
      to_sample();
      check($sformatf("vec%0d_idle_busy", v), bus.busy, 0);
      check($sformatf("vec%0d_tmo", v), bus.timeout_err, vecs[v].exp_err);
      check($sformatf("vec%0d_ovr", v), bus.overrun, 0);
      to_drive();
    end

    // ---------------- reset mid-WAIT with grant 2 ----------------
    do_reset();
    xs = {$urandom(), $urandom()};
    bus.x_in = xs;
    bus.y_in = $urandom();
    bus.colour_in = 12'($urandom());
    bus.plot_in = 4'b1111;
    bus.frame_tick = 1'b1;
    bus.req = 4'b0100;
    to_sample(); to_drive();                         // r0 IDLE
    bus.frame_tick = 1'b0;
    to_sample(); to_drive();                         // r1 SELECT
    bus.frame_tick = 1'b1;
    bus.req = 4'b1111;
    to_sample();                                     // r2 START
    check("rstw_start", bus.start, 4'b0100);
    to_drive();
    bus.frame_tick = 1'b0;
    to_sample(); to_drive();                         // r3 WAIT
    to_sample();                                     // r4 WAIT
    check("rstw_grant_pre", bus.grant_idx, 2);
    check("rstw_x_pre", bus.x, xs[18 +: 9]);
    check("rstw_plot_pre", bus.plot, 1);
    check("rstw_ovr_pre", bus.overrun, 1);
    to_drive();
    resetn = 1'b0;
    to_sample(); to_drive();                         // r5 reset sampled
    resetn = 1'b1;
    to_sample();                                     // r6
    check("rstw_busy",   bus.busy,        0);
    check("rstw_start0", bus.start,       0);
    check("rstw_x",      bus.x,           0);
    check("rstw_y",      bus.y,           0);
    check("rstw_colour", bus.colour,      0);
    check("rstw_plot",   bus.plot,        0);
    check("rstw_grant",  bus.grant_idx,   0);
    check("rstw_tmo",    bus.timeout_err, 0);
    check("rstw_ovr",    bus.overrun,     0);
    to_drive();

    // ------- spurious done_in[3], then done coinciding with expiry -------
    do_reset();
    for (int r = 0; r <= 28; r++) begin
      bus.frame_tick = (r == 0);
      bus.req = (r == 0) ? 4'b1001 : 4'b0110;
      bus.done_in = (r == 5)  ? 4'b1000 :
                    (r == 18) ? 4'b0001 :
                    (r == 25) ? 4'b1000 : 4'b0000;
      to_sample();
      check($sformatf("spur_start_r%0d", r), bus.start,
            (r == 2) ? 4'b0001 : (r == 20) ? 4'b1000 : 4'b0000);
      check($sformatf("spur_pass_done_r%0d", r), bus.pass_done, (r == 27));
      to_drive();
    end
    to_sample();
    check("spur_tmo", bus.timeout_err, 0);
    check("spur_busy", bus.busy, 0);
    to_drive();

    // ---------------- overrun during WAIT ----------------
    do_reset();
    for (int r = 0; r <= 17; r++) begin
      bus.frame_tick = (r == 0 || r == 4);
      bus.req = (r == 0) ? 4'b0011 : 4'b1100;
      bus.done_in = (r == 7) ? 4'b0001 : (r == 14) ? 4'b0010 : 4'b0000;
      to_sample();
      check($sformatf("ovr_start_r%0d", r), bus.start,
            (r == 2) ? 4'b0001 : (r == 9) ? 4'b0010 : 4'b0000);
      check($sformatf("ovr_pass_done_r%0d", r), bus.pass_done, (r == 16));
      check($sformatf("ovr_busy_r%0d", r), bus.busy, (r >= 1 && r <= 16));
      check($sformatf("ovr_flag_r%0d", r), bus.overrun, (r >= 5));
      to_drive();
    end

    // ---------------- empty request set ----------------
    do_reset();
    for (int r = 0; r <= 3; r++) begin
      bus.frame_tick = (r == 0);
      bus.req = '0;
      to_sample();
      check($sformatf("empty_start_r%0d", r), bus.start, 0);
      check($sformatf("empty_pass_done_r%0d", r), bus.pass_done, (r == 2));
      check($sformatf("empty_busy_r%0d", r), bus.busy, (r == 1 || r == 2));
      to_drive();
    end

    // ---------------- randomized passes vs schedule model ----------------
    do_reset();
    exp_err = 1'b0;
    exp_ovr = 1'b0;
    for (int p = 0; p < 40; p++) begin
      rq = (p % 8 == 0) ? 4'b0000 : 4'($urandom);
      for (int i = 0; i < N; i++)
        dly_r[i] = ($urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(1, TO + 1));

      // Schedule: each requested plotter, in index order, starts 2 cycles
      // after the previous one ended; it ends on its done or after TO+1
      // cycles, whichever is first. pass_done follows the last end by 2.
      for (int r = 0; r < MAXR; r++) begin
        exp_start[r] = '0;
        exp_g[r]     = -1;
      end
      t = 2;
      err_at = -1;
      for (int i = 0; i < N; i++) begin
        if (rq[i]) begin
          exp_start[t] = 4'(1 << i);
          if (dly_r[i] <= TO + 1) e = t + dly_r[i];
          else begin
            e = t + TO + 1;
            if (err_at < 0) err_at = e + 1;
          end
          for (int r = t; r <= e; r++) exp_g[r] = i;
          t = e + 2;
        end
      end
      pd = t;

      act = -1;
      cnt = 0;
      for (int r = 0; r <= pd + 1; r++) begin
        tick_now = (r == 0) || (r <= pd && $urandom_range(0, 19) == 0);
        bus.frame_tick = tick_now;
        bus.req = (r == 0) ? rq : 4'($urandom);
        bus.x_in = {$urandom(), $urandom()};
        bus.y_in = $urandom();
        bus.colour_in = 12'($urandom());
        bus.plot_in = 4'($urandom());
        dn = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
        if (act >= 0) begin
          dn[act] = 1'b0;
          cnt++;
          if (cnt == dly_r[act]) begin
            dn[act] = 1'b1;
            act = -1;
          end
        end
        bus.done_in = dn;
        to_sample();
        if (r == err_at) exp_err = 1'b1;
        g = exp_g[r];
        check("rnd_start", bus.start, exp_start[r]);
        check("rnd_pass_done", bus.pass_done, (r == pd));
        check("rnd_busy", bus.busy, (r >= 1 && r <= pd));
        check("rnd_tmo", bus.timeout_err, exp_err);
        check("rnd_ovr", bus.overrun, exp_ovr);
        if (g >= 0) begin
          check("rnd_grant", bus.grant_idx, g);
          check("rnd_x", bus.x, bus.x_in[9*g +: 9]);
          check("rnd_y", bus.y, bus.y_in[8*g +: 8]);
          check("rnd_colour", bus.colour, bus.colour_in[3*g +: 3]);
          check("rnd_plot", bus.plot, bus.plot_in[g]);
        end else begin
          check("rnd_pix_idle", {bus.x, bus.y, bus.colour, bus.plot}, 0);
        end
        if (bus.start != '0) begin
          for (int i = 0; i < N; i++) if (bus.start[i]) act = i;
          cnt = 0;
        end
        if (tick_now && r >= 1) exp_ovr = 1'b1;
        to_drive();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
